unary_add_1_4: RTL and testbench

//  Serial unary (pulse-count) adder with a 4-bit accumulator.
//  - Write phase: each cycle adds the number of high bits on A and B (0, 1 or 2) into the accumulator.
//  - Read phase: replays the accumulated total as a unary stream on dout, one '1' per clock.
//  - Leaf datapath block for unary/stochastic arithmetic chains; C flags accumulator overflow.

---
 rtl/unary_add_pkg.sv | 12 +
 rtl/unary_acc_core.sv | 54 +++++
 rtl/unary_add_1_4.sv | 48 ++++
 tb/tb_unary_add_1_4.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_add_pkg.sv
// Shared constants for the unary pulse-count adder: default width, capacity, mode encoding.
// No logic; imported by the accumulator core, the top and the bench.
// Not applicable: holds no flow-controlled interfaces.
package unary_add_pkg;

    localparam int CNT_W_DEFAULT = 4;
    localparam int CNT_MAX       = 2**CNT_W_DEFAULT - 1;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

endpackage

// File: rtl/unary_acc_core.sv
// Accumulator core: adds A+B ones on write, decrements on read, raises the sticky carry flag.
// Latency: count and c update on the clock edge that samples wr_en/rd_en.
// No backpressure: holds state whenever neither wr_en nor rd_en is set.
module unary_acc_core
    import unary_add_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic             c
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] count_nxt;
    logic             c_nxt;

    always_comb begin
        sum       = {1'b0, count} + {{CNT_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        count_nxt = count;
        c_nxt     = c;
        if (wr_en) begin
`ifdef UNARY_ADD_WRAP_EN
            count_nxt = sum[CNT_W-1:0];
`else
            count_nxt = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`endif
            // At most two ones arrive per cycle, so the carry bit alone marks overflow.
            if (sum[CNT_W]) begin
                c_nxt = 1'b1;
            end
        end else if (rd_en && (count != '0)) begin
            count_nxt = count - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            c     <= 1'b0;
        end else begin
            count <= count_nxt;
            c     <= c_nxt;
        end
    end

endmodule

// File: rtl/unary_add_1_4.sv
// Serial unary adder: accumulates ones from A/B, replays the total on dout. Build option: UNARY_ADD_WRAP_EN (wrap instead of saturate).
// Latency: dout goes high on the first edge after read mode is sampled; one '1' per clock.
// No backpressure: en=0 freezes all state and forces dout low.
module unary_add_1_4
    import unary_add_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic en,
    input  logic read_or_write,
    output logic dout,
    output logic C
);

    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = en && (read_or_write == MODE_WRITE);
    assign rd_en = en && (read_or_write == MODE_READ);

    unary_acc_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .a     (A),
        .b     (B),
        .count (count),
        .c     (C)
    );

    // Emit a one for every stored unit; the core decrements on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b0;
        end else begin
            dout <= rd_en && (count != '0);
        end
    end

endmodule

// File: tb/tb_unary_add_1_4.sv
// Bench for unary_add_1_4: directed scenarios plus random traffic against a pulse-count reference model.
module tb_unary_add_1_4;
    import unary_add_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic A = 1'b0;
    logic B = 1'b0;
    logic en = 1'b0;
    logic read_or_write = 1'b0;
    logic dout;
    logic C;

    int errors = 0;
    int checks = 0;

    // Reference model: number of stored ones, sticky overflow, expected dout.
    int m_count = 0;
    bit m_c = 1'b0;
    bit m_dout = 1'b0;

    unary_add_1_4 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one clock of stimulus, advance the model, sample #1 after the edge.
    task automatic cycle(input bit e, input bit rw, input bit a, input bit b);
        int total;
        en = e;
        read_or_write = rw;
        A = a;
        B = b;
        @(posedge clk);
        m_dout = 1'b0;
        if (e) begin
            if (!rw) begin
                total = m_count + int'(a) + int'(b);
                if (total > CNT_MAX) m_c = 1'b1;
`ifdef UNARY_ADD_WRAP_EN
                m_count = total % (CNT_MAX + 1);
`else
                m_count = (total > CNT_MAX) ? CNT_MAX : total;
`endif
            end else if (m_count > 0) begin
                m_dout = 1'b1;
                m_count = m_count - 1;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0;
        rst_n = 1'b0;
        m_count = 0;
        m_c = 1'b0;
        m_dout = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        A = 1'b1;
        B = 1'b1;
        read_or_write = MODE_WRITE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dut.count !== 4'd0) begin
                errors++;
                $display("FAIL reset_count: got %0d want 0", dut.count);
            end
            checks++;
            if (dout !== 1'b0) begin
                errors++;
                $display("FAIL reset_dout: got %b want 0", dout);
            end
            checks++;
            if (C !== 1'b0) begin
                errors++;
                $display("FAIL reset_c: got %b want 0", C);
            end
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        int ones;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, MODE_WRITE, 1'b1, 1'b1);
            cycle(1'b1, MODE_WRITE, 1'b0, 1'b0);
        end
        checks++;
        if (dut.count !== 4'd6 || dut.count !== 4'(m_count)) begin
            errors++;
            $display("FAIL write6_count: got %0d want 6", dut.count);
        end
        checks++;
        if (C !== 1'b0) begin
            errors++;
            $display("FAIL write6_c: got %b want 0", C);
        end
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, MODE_READ, 1'b1, 1'b1);
            ones += int'(dout);
            checks++;
            if (dout !== m_dout) begin
                errors++;
                $display("FAIL read6_dout[%0d]: got %b want %b", i, dout, m_dout);
            end
        end
        checks++;
        if (ones != 6) begin
            errors++;
            $display("FAIL read6_ones: got %0d want 6", ones);
        end
        checks++;
        if (dut.count !== 4'd0) begin
            errors++;
            $display("FAIL read6_count: got %0d want 0", dut.count);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, MODE_WRITE, 1'b1, 1'b0);
        checks++;
        if (dut.count !== 4'd5) begin
            errors++;
            $display("FAIL hold_write_count: got %0d want 5", dut.count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'(i % 2), 1'b1, 1'b1);
            checks++;
            if (dut.count !== 4'd5 || dout !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got count=%0d dout=%b want count=5 dout=0", i, dut.count, dout);
            end
        end
    endtask

    task automatic test_overflow();
        int ones;
        int want_ones;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, MODE_WRITE, 1'b1, 1'b1);
            cycle(1'b1, MODE_WRITE, 1'b0, 1'b0);
        end
`ifdef UNARY_ADD_WRAP_EN
        want_ones = 2;
`else
        want_ones = 15;
`endif
        checks++;
        if (dut.count !== 4'(want_ones) || dut.count !== 4'(m_count)) begin
            errors++;
            $display("FAIL ovf_count: got %0d want %0d", dut.count, want_ones);
        end
        checks++;
        if (C !== 1'b1) begin
            errors++;
            $display("FAIL ovf_c: got %b want 1", C);
        end
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, MODE_READ, 1'b0, 1'b1);
            ones += int'(dout);
        end
        checks++;
        if (ones != want_ones) begin
            errors++;
            $display("FAIL ovf_read_ones: got %0d want %0d", ones, want_ones);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, MODE_WRITE, 1'b0, 1'b0);
        checks++;
        if (C !== 1'b1) begin
            errors++;
            $display("FAIL ovf_c_sticky: got %b want 1", C);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, MODE_WRITE, 1'b1, 1'b1);
        cycle(1'b1, MODE_READ, 1'b0, 1'b0);
        cycle(1'b1, MODE_READ, 1'b0, 1'b0);
        checks++;
        if (dout !== 1'b1 || C !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got dout=%b C=%b want dout=1 C=1", dout, C);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.count !== 4'd0 || dout !== 1'b0 || C !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got count=%0d dout=%b C=%b want 0 0 0", dut.count, dout, C);
        end
        apply_reset();
    endtask

    task automatic test_random();
        bit e, rw, a, b;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            rw = ((i / 25) % 2 == 1) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            a  = 1'($urandom);
            b  = 1'($urandom);
            cycle(e, rw, a, b);
            checks++;
            if (dut.count !== 4'(m_count) || dout !== m_dout || C !== m_c) begin
                errors++;
                $display("FAIL random[%0d]: got count=%0d dout=%b C=%b want count=%0d dout=%b C=%b",
                         i, dut.count, dout, C, m_count, m_dout, m_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
